int_to_int_issuer: RTL

Command-driven sequencer on the initiator side of the INT-to-INT conversion array. It accepts one conversion command (control bits, source address, destination address, vector count) and streams 128-bit vectors from the vector register file into the array's data/micro-instruction inputs. It captures the array's registered results and micro-instruction echo, writes the results back to the register file, and signals completion. The block sits between the command decoder and the conversion array.

---
 rtl/int_to_int_pkg.sv | 23 ++
 rtl/int_to_int_issuer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/int_to_int_pkg.sv
// Shared definitions for the INT-to-INT conversion array initiator side:
// micro-instruction layout, vector width and issuer FSM states.
package int_to_int_pkg;

  localparam int UI_W          = 7;
  localparam int VEC_W         = 128;

  localparam int UI_VLD        = 6;
  localparam int UI_SRC_PREC   = 5;
  localparam int UI_DST_PREC   = 4;
  localparam int UI_SRC_SIGNED = 3;
  localparam int UI_DST_SIGNED = 2;
  localparam int UI_SRC_POS    = 1;
  localparam int UI_DST_POS    = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/int_to_int_issuer.sv
// Command sequencer: streams register-file vectors into the INT-to-INT array
// and writes the array's results back, one vector per cycle.
module int_to_int_issuer
  import int_to_int_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [5:0]          cmd_ctrl,
  input  logic [AW-1:0]       cmd_src_addr,
  input  logic [AW-1:0]       cmd_dst_addr,
  input  logic [7:0]          cmd_len,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [VEC_W-1:0]    rd_data,
  output logic [VEC_W-1:0]    dvr_inttoint_s_out,
  output logic [UI_W-1:0]     cru_inttoint_issue,
  input  logic [VEC_W-1:0]    dr_inttoint_d_in,
  input  logic [UI_W-1:0]     cru_inttoint_ret,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [VEC_W-1:0]    wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t             state;
  logic [5:0]         ctrl_q;
  logic [AW-1:0]      src_q;
  logic [AW-1:0]      dst_q;
  logic [7:0]         len_q;
  logic [7:0]         rd_cnt;
  logic [7:0]         wr_cnt;

  logic               vld_p0;
  logic [VEC_W-1:0]   s_out_p1;
  logic [UI_W-1:0]    issue_p1;
  logic               wr_en_p2;
  logic [AW-1:0]      wr_addr_p2;
  logic [VEC_W-1:0]   wr_data_p2;

  logic               wb_fire;
  logic               echo_bad;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_en     = (state == READ);
  assign rd_addr   = src_q + AW'(rd_cnt);

  // Returns outside an active command are stray and must not write or flag.
  assign wb_fire  = cru_inttoint_ret[UI_VLD] && ((state == READ) || (state == DRAIN));
  assign echo_bad = (cru_inttoint_ret[UI_VLD-1:0] != ctrl_q);

  assign dvr_inttoint_s_out = s_out_p1;
  assign cru_inttoint_issue = issue_p1;
  assign wr_en              = wr_en_p2;
  assign wr_addr            = wr_addr_p2;
  assign wr_data            = wr_data_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctrl_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      err        <= 1'b0;
      vld_p0     <= 1'b0;
      s_out_p1   <= '0;
      issue_p1   <= '0;
      wr_en_p2   <= 1'b0;
      wr_addr_p2 <= '0;
      wr_data_p2 <= '0;
    end else begin
      // p0: read strobe delayed to line up with rd_data
      vld_p0 <= rd_en;

      // p1: issue stage toward the array
      if (vld_p0) begin
        s_out_p1 <= rd_data;
        issue_p1 <= {1'b1, ctrl_q};
      end else begin
        issue_p1 <= {1'b0, ctrl_q};
      end

      // p2: write-back of array results
      wr_en_p2 <= wb_fire;
      if (wb_fire) begin
        wr_addr_p2 <= dst_q + AW'(wr_cnt);
        wr_data_p2 <= dr_inttoint_d_in;
        wr_cnt     <= wr_cnt + 8'd1;
        if (echo_bad) begin
          err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ctrl_q <= cmd_ctrl;
            src_q  <= cmd_src_addr;
            dst_q  <= cmd_dst_addr;
            len_q  <= cmd_len;
            rd_cnt <= '0;
            wr_cnt <= '0;
            err    <= 1'b0;
            state  <= (cmd_len == 8'd0) ? DONE : READ;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + 8'd1;
          if (rd_cnt == len_q - 8'd1) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // wr_cnt has already advanced past the index just written
          if (wr_en_p2 && (wr_cnt == len_q)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
